uart_rx_param: RTL

Parametrised UART receiver and the successor to the fixed 8N1, 4x-oversampled receiver. Data width, stop-bit count and oversampling ratio are generics. Adds input synchronisation, start-bit glitch rejection, 3-sample majority voting, a one-cycle data-valid strobe and framing-error reporting. Sits between the board RxD pin and the game-control byte decoder.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_tick.sv | 26 ++
 rtl/uart_rx_param.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and elaboration helpers for the receiver and the planned transmitter.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
      return clk_freq / (baud_rate * oversample);
   endfunction

   function automatic int calc_mid(input int oversample);
      return oversample / 2;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick divider, counts 0..DIV-1 and pulses on the last count.
module uart_baud_tick #(
   parameter int DIV = 1
)(
   input  logic clk_fpga,
   input  logic reset,
   input  logic i_clr,
   output logic o_tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == CW'(DIV - 1));
   assign o_tick = !i_clr && w_last;

   always_ff @(posedge clk_fpga) begin
      if (reset || i_clr)
         r_cnt <= '0;
      else
         r_cnt <= w_last ? '0 : r_cnt + CW'(1);
   end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver with glitch rejection and majority vote.
// Define UART_RX_PARITY_EN to add a parity bit check (PARITY_ODD selects odd parity).
module uart_rx_param #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 9_600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1
`ifdef UART_RX_PARITY_EN
  ,parameter int PARITY_ODD = 0
`endif
)(
   input  logic                 clk_fpga,
   input  logic                 reset,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 busy
);

   import uart_pkg::*;

   localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int MID = calc_mid(OVERSAMPLE);
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
`endif

   if (DIV < 1 || OVERSAMPLE < 4 || OVERSAMPLE % 2 != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_chk
      $error("uart_rx_param: illegal parameter combination");
   end

   state_t                r_state, w_next;
   logic                  r_sync1, r_sync2, r_prev;
   logic                  w_rxd_s, w_clr, w_tick, w_res, w_end, w_vote, w_bad, w_exit;
   logic [SW-1:0]         r_samp;
   logic [BW-1:0]         r_bit;
   logic                  r_v0, r_v1, r_err, r_valid, r_ferr;
   logic [DATA_BITS-1:0]  r_shift, r_data;

   assign w_rxd_s   = r_sync2;
   assign w_clr     = (r_state == IDLE);
   assign w_res     = w_tick && (r_samp == SW'(MID + 1));
   assign w_end     = w_tick && (r_samp == SW'(OVERSAMPLE - 1));
   assign w_vote    = (r_v0 & r_v1) | (r_v0 & w_rxd_s) | (r_v1 & w_rxd_s);
   assign w_bad     = r_err || !w_vote;
   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign frame_err = r_ferr;
   assign busy      = (r_state != IDLE);

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk_fpga (clk_fpga),
      .reset    (reset),
      .i_clr    (w_clr),
      .o_tick   (w_tick)
   );

   always_ff @(posedge clk_fpga) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // Stop exits at its mid-bit vote so a start edge right after the stop bit is not missed.
   always_comb begin
      w_next = r_state;
      w_exit = 1'b0;
      case (r_state)
         IDLE:   w_next = (r_prev && !w_rxd_s) ? START : IDLE;
         START:  w_next = (w_res && w_vote) ? IDLE : (w_end ? DATA : START);
         DATA:   w_next = (w_end && r_bit == BW'(DATA_BITS - 1)) ? AFTER_DATA : DATA;
`ifdef UART_RX_PARITY_EN
         PARITY: w_next = w_end ? STOP : PARITY;
`endif
         STOP: begin
            w_exit = w_res && (r_bit == BW'(STOP_BITS - 1));
            w_next = w_exit ? IDLE : STOP;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_fpga) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
         r_samp  <= '0;
         r_bit   <= '0;
         r_v0    <= 1'b0;
         r_v1    <= 1'b0;
         r_err   <= 1'b0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_sync1 <= rxd;
         r_sync2 <= r_sync1;
         r_prev  <= w_rxd_s;
         r_samp  <= (w_clr || w_end) ? '0 : r_samp + SW'(w_tick);
         r_v0    <= (w_tick && r_samp == SW'(MID - 1)) ? w_rxd_s : r_v0;
         r_v1    <= (w_tick && r_samp == SW'(MID)) ? w_rxd_s : r_v1;
         r_bit   <= (w_next != r_state) ? '0 :
                    r_bit + BW'(w_end && (r_state == DATA || r_state == STOP));
         r_shift <= (r_state == DATA && w_res) ? {w_vote, r_shift[DATA_BITS-1:1]} : r_shift;
         r_err   <= (r_state == STOP) && (r_err || (w_res && !w_vote));
         r_valid <= w_exit && !w_bad;
         r_ferr  <= w_exit && w_bad;
         r_data  <= (w_exit && !w_bad) ? r_shift : r_data;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_par, r_perr;

   assign parity_err = r_perr;

   always_ff @(posedge clk_fpga) begin
      if (reset) begin
         r_par  <= 1'b0;
         r_perr <= 1'b0;
      end else begin
         r_par  <= (r_state == PARITY && w_res) ? w_vote : r_par;
         r_perr <= w_exit && !w_bad && ((^r_shift ^ r_par) != 1'(PARITY_ODD));
      end
   end
`endif

endmodule
